ace_snoop_responder: RTL and testbench



---
 rtl/ace_snoop_responder_if.sv | 56 +++++
 rtl/ace_snoop_responder.sv | 146 ++++++++++++++
 tb/tb_ace_snoop_responder.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ace_snoop_responder_if.sv
// Snoop-side bundle of the ACE responder: AC/CR/CD channels and the cache lookup port.
// The slave modport is the responder; the master modport is the interconnect/cache side.
interface ace_snoop_responder_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned LineWidth = 128
);
    logic                 ac_valid_i;
    logic                 ac_ready_o;
    logic [AddrWidth-1:0] ac_addr_i;
    logic [3:0]           ac_snoop_i;
    logic [2:0]           ac_prot_i;

    logic                 cr_valid_o;
    logic                 cr_ready_i;
    logic [4:0]           cr_resp_o;

    logic                 cd_valid_o;
    logic                 cd_ready_i;
    logic [DataWidth-1:0] cd_data_o;
    logic                 cd_last_o;

    logic                 lk_req_o;
    logic                 lk_gnt_i;
    logic [AddrWidth-1:0] lk_addr_o;
    logic [3:0]           lk_snoop_o;
    logic [2:0]           lk_prot_o;

    logic                 lk_rvalid_i;
    logic [4:0]           lk_resp_i;
    logic [LineWidth-1:0] lk_line_i;

    modport slave (
        input  ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i,
        output ac_ready_o,
        output cr_valid_o, cr_resp_o,
        input  cr_ready_i,
        output cd_valid_o, cd_data_o, cd_last_o,
        input  cd_ready_i,
        output lk_req_o, lk_addr_o, lk_snoop_o, lk_prot_o,
        input  lk_gnt_i,
        input  lk_rvalid_i, lk_resp_i, lk_line_i
    );

    modport master (
        output ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i,
        input  ac_ready_o,
        input  cr_valid_o, cr_resp_o,
        output cr_ready_i,
        input  cd_valid_o, cd_data_o, cd_last_o,
        output cd_ready_i,
        input  lk_req_o, lk_addr_o, lk_snoop_o, lk_prot_o,
        output lk_gnt_i,
        output lk_rvalid_i, lk_resp_i, lk_line_i
    );
endinterface

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: queues AC requests, looks each up in the cache,
// answers on CR and streams the line on CD in DataWidth beats.
module ace_snoop_responder #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned LineWidth = 128,
    parameter int unsigned Depth     = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    ace_snoop_responder_if.slave           bus,
    output logic [$clog2(Depth+1)-1:0]     pending_o
);
    localparam int unsigned Beats = LineWidth / DataWidth;
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW  = $clog2(Depth + 1);
    localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;

    if ((LineWidth % DataWidth) != 0 || Depth < 1) begin : g_bad_cfg
        $error("ace_snoop_responder: bad LineWidth/DataWidth/Depth");
    end

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [3:0]           snoop;
        logic [2:0]           prot;
    } ac_req_t;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WAIT, RESP, DATA
    } state_e;

    state_e               state_q, state_d;
    ac_req_t              fifo_q [Depth];
    ac_req_t              fifo_d [Depth];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    ac_req_t              srv_q, srv_d;
    logic [4:0]           resp_q, resp_d;
    logic [LineWidth-1:0] line_q, line_d;
    logic [BeatW-1:0]     beat_q, beat_d;

    logic full, empty, push, pop, last_beat;
    logic [Beats-1:0][DataWidth-1:0] line_beats;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full       = (count_q == CntW'(Depth));
    assign empty      = (count_q == '0);
    assign push       = bus.ac_valid_i && !full;
    assign pop        = (state_q == IDLE) && !empty;
    assign last_beat  = (beat_q == BeatW'(Beats - 1));
    assign line_beats = line_q;

    always_comb begin
        state_d  = state_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);
        srv_d    = srv_q;
        resp_d   = resp_q;
        line_d   = line_q;
        beat_d   = beat_q;

        if (push) begin
            fifo_d[wr_ptr_q] = '{addr:  bus.ac_addr_i,
                                 snoop: bus.ac_snoop_i,
                                 prot:  bus.ac_prot_i};
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    srv_d    = fifo_q[rd_ptr_q];
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.lk_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (bus.lk_rvalid_i) begin
                    resp_d  = bus.lk_resp_i;
                    line_d  = bus.lk_line_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.cr_ready_i) begin
                    beat_d  = '0;
                    state_d = resp_q[0] ? DATA : IDLE;
                end
            end
            DATA: begin
                if (bus.cd_ready_i) begin
                    if (last_beat) state_d = IDLE;
                    else           beat_d  = beat_q + BeatW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            srv_q    <= '0;
            resp_q   <= '0;
            line_q   <= '0;
            beat_q   <= '0;
            for (int i = 0; i < Depth; i++) fifo_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            srv_q    <= srv_d;
            resp_q   <= resp_d;
            line_q   <= line_d;
            beat_q   <= beat_d;
        end
    end

    // Payloads are gated by their valids so idle channels read as zero.
    assign bus.ac_ready_o = !full;
    assign bus.lk_req_o   = (state_q == LOOKUP);
    assign bus.lk_addr_o  = bus.lk_req_o ? srv_q.addr  : '0;
    assign bus.lk_snoop_o = bus.lk_req_o ? srv_q.snoop : '0;
    assign bus.lk_prot_o  = bus.lk_req_o ? srv_q.prot  : '0;
    assign bus.cr_valid_o = (state_q == RESP);
    assign bus.cr_resp_o  = bus.cr_valid_o ? resp_q : '0;
    assign bus.cd_valid_o = (state_q == DATA);
    assign bus.cd_data_o  = bus.cd_valid_o ? line_beats[beat_q] : '0;
    assign bus.cd_last_o  = bus.cd_valid_o && last_beat;
    assign pending_o      = count_q + CntW'(state_q != IDLE);
endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder: a queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_ace_snoop_responder;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int LW    = 128;
    localparam int DEPTH = 2;
    localparam int BEATS = LW / DW;

    localparam int P_IDLE = 0;
    localparam int P_LOOK = 1;
    localparam int P_WAIT = 2;
    localparam int P_RESP = 3;
    localparam int P_DATA = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pending;
    int         checks = 0;
    int         errors = 0;

    ace_snoop_responder_if #(
        .AddrWidth(AW), .DataWidth(DW), .LineWidth(LW)
    ) bus ();

    ace_snoop_responder #(
        .AddrWidth(AW), .DataWidth(DW),
        .LineWidth(LW), .Depth(DEPTH)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .bus      (bus),
        .pending_o(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: queue of accepted snoops and the service phase
    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    snoop;
        logic [2:0]    prot;
    } req_t;

    req_t          mq[$];
    req_t          msrv;
    int            mphase = P_IDLE;
    logic [4:0]    mresp = '0;
    logic [LW-1:0] mline = '0;
    int            mbeat = 0;
    int            mpend = 0;
    bit            m_push, m_done;
    logic [LW-1:0] m_sh;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mphase = P_IDLE;
            mbeat  = 0;
            mpend  = 0;
        end else begin
            m_push = bus.ac_valid_i && (mq.size() < DEPTH);
            m_done = 0;
            case (mphase)
                P_IDLE: if (mq.size() > 0) begin
                    msrv   = mq.pop_front();
                    mphase = P_LOOK;
                end
                P_LOOK: if (bus.lk_gnt_i) mphase = P_WAIT;
                P_WAIT: if (bus.lk_rvalid_i) begin
                    mresp  = bus.lk_resp_i;
                    mline  = bus.lk_line_i;
                    mphase = P_RESP;
                end
                P_RESP: if (bus.cr_ready_i) begin
                    mbeat = 0;
                    if (mresp[0]) mphase = P_DATA;
                    else begin
                        mphase = P_IDLE;
                        m_done = 1;
                    end
                end
                P_DATA: if (bus.cd_ready_i) begin
                    if (mbeat == BEATS - 1) begin
                        mphase = P_IDLE;
                        m_done = 1;
                    end else mbeat++;
                end
                default: mphase = P_IDLE;
            endcase
            if (m_push)
                mq.push_back('{bus.ac_addr_i, bus.ac_snoop_i,
                               bus.ac_prot_i});
            mpend = mpend + int'(m_push) - int'(m_done);
        end
    end

    // Per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            chk("rst_ac_ready", bus.ac_ready_o, 1'b1);
            chk("rst_lk_req", bus.lk_req_o, 1'b0);
            chk("rst_lk_addr", bus.lk_addr_o, '0);
            chk("rst_cr_valid", bus.cr_valid_o, 1'b0);
            chk("rst_cd_valid", bus.cd_valid_o, 1'b0);
            chk("rst_cd_data", bus.cd_data_o, '0);
            chk("rst_pending", pending, '0);
        end else begin
            chk("ac_ready", bus.ac_ready_o, mq.size() < DEPTH);
            chk("lk_req", bus.lk_req_o, mphase == P_LOOK);
            if (mphase == P_LOOK) begin
                chk("lk_addr", bus.lk_addr_o, msrv.addr);
                chk("lk_snoop", bus.lk_snoop_o, msrv.snoop);
                chk("lk_prot", bus.lk_prot_o, msrv.prot);
            end
            chk("cr_valid", bus.cr_valid_o, mphase == P_RESP);
            if (mphase == P_RESP)
                chk("cr_resp", bus.cr_resp_o, mresp);
            chk("cd_valid", bus.cd_valid_o, mphase == P_DATA);
            if (mphase == P_DATA) begin
                m_sh = mline >> (mbeat * DW);
                chk("cd_data", bus.cd_data_o, m_sh[DW-1:0]);
                chk("cd_last", bus.cd_last_o, mbeat == BEATS - 1);
            end
            chk("pending", pending, mpend[1:0]);
        end
    end

    // Cache side: result one cycle after each grant
    logic [4:0]    cur_resp = '0;
    logic [LW-1:0] cur_line = '0;
    bit            addr_resp = 0;
    bit            fire = 0;
    logic [AW-1:0] fire_addr = '0;

    initial forever begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            bus.lk_rvalid_i = 1'b0;
            fire = 0;
        end else begin
            bus.lk_rvalid_i = fire;
            if (fire) begin
                bus.lk_resp_i = addr_resp ?
                    {fire_addr[8:6], 2'b00} : cur_resp;
                bus.lk_line_i = cur_line;
            end
            fire      = bus.lk_req_o && bus.lk_gnt_i;
            fire_addr = bus.lk_addr_o;
        end
    end

    // Handshake log
    int             cr_hs = 0;
    int             cd_hs = 0;
    int             cd_lasts = 0;
    logic [4:0]     cr_log[$];
    logic [DW-1:0]  cd_log[$];

    initial forever begin
        @(negedge clk);
        #3;
        if (rst_n) begin
            if (bus.cr_valid_o && bus.cr_ready_i) begin
                cr_hs++;
                cr_log.push_back(bus.cr_resp_o);
            end
            if (bus.cd_valid_o && bus.cd_ready_i) begin
                cd_hs++;
                cd_log.push_back(bus.cd_data_o);
                if (bus.cd_last_o) cd_lasts++;
            end
        end
    end

    task automatic clr_log();
        cr_hs = 0;
        cd_hs = 0;
        cd_lasts = 0;
        cr_log.delete();
        cd_log.delete();
    endtask

    // Called at a negedge; returns at the negedge after acceptance
    task automatic send_ac(input logic [AW-1:0] a, output int waited);
        bus.ac_valid_i = 1'b1;
        bus.ac_addr_i  = a;
        bus.ac_snoop_i = a[9:6];
        bus.ac_prot_i  = a[12:10];
        waited = 0;
        forever begin
            #1;
            if (bus.ac_ready_o) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
            waited++;
            if (waited > 60) begin
                chk("ac_accept_timeout", 1'b0, 1'b1);
                break;
            end
        end
    endtask

    logic          s_lk  [0:7];
    logic          s_cr  [0:7];
    logic [4:0]    s_rsp [0:7];
    logic          s_cdv [0:7];
    logic [DW-1:0] s_cdd [0:7];
    logic          s_lst [0:7];
    logic [1:0]    s_pnd [0:7];
    logic          s_rdy0;

    task automatic run_single(input logic [AW-1:0] a);
        @(negedge clk);
        bus.ac_valid_i = 1'b1;
        bus.ac_addr_i  = a;
        bus.ac_snoop_i = 4'h9;
        bus.ac_prot_i  = 3'h5;
        #3 s_rdy0 = bus.ac_ready_o;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            bus.ac_valid_i = 1'b0;
            #3;
            s_lk[c]  = bus.lk_req_o;
            s_cr[c]  = bus.cr_valid_o;
            s_rsp[c] = bus.cr_resp_o;
            s_cdv[c] = bus.cd_valid_o;
            s_cdd[c] = bus.cd_data_o;
            s_lst[c] = bus.cd_last_o;
            s_pnd[c] = pending;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int w;
    int seen;
    logic [AW-1:0] addrs [4];

    initial begin
        bus.ac_valid_i = 1'b0;
        bus.ac_addr_i  = '0;
        bus.ac_snoop_i = '0;
        bus.ac_prot_i  = '0;
        bus.cr_ready_i = 1'b0;
        bus.cd_ready_i = 1'b0;
        bus.lk_gnt_i   = 1'b0;
        bus.lk_rvalid_i = 1'b0;
        bus.lk_resp_i  = '0;
        bus.lk_line_i  = '0;
        repeat (3) @(negedge clk);
        #3;
        chk("reset_ac_ready", bus.ac_ready_o, 1'b1);
        chk("reset_pending", pending, 2'd0);
        rst_n = 1'b1;

        // Single snoop with data: minimum latency
        bus.lk_gnt_i   = 1'b1;
        bus.cr_ready_i = 1'b1;
        bus.cd_ready_i = 1'b1;
        cur_resp = 5'b00001;
        cur_line = {{16{4'hA}}, {16{4'hB}}};
        run_single(64'h40);
        chk("t1_ready_c0", s_rdy0, 1'b1);
        chk("t1_pend_c1", s_pnd[1], 2'd1);
        chk("t1_lk_c1", s_lk[1], 1'b0);
        chk("t1_lk_c2", s_lk[2], 1'b1);
        chk("t1_cr_c3", s_cr[3], 1'b0);
        chk("t1_cr_c4", s_cr[4], 1'b1);
        chk("t1_resp_c4", s_rsp[4], 5'b00001);
        chk("t1_cdv_c5", s_cdv[5], 1'b1);
        chk("t1_data0", s_cdd[5], {16{4'hB}});
        chk("t1_last0", s_lst[5], 1'b0);
        chk("t1_data1", s_cdd[6], {16{4'hA}});
        chk("t1_last1", s_lst[6], 1'b1);
        chk("t1_cdv_c7", s_cdv[7], 1'b0);
        chk("t1_pend_c7", s_pnd[7], 2'd0);

        // IsShared, no data
        cur_resp = 5'b01000;
        run_single(64'h80);
        chk("t2_cr_c4", s_cr[4], 1'b1);
        chk("t2_resp_c4", s_rsp[4], 5'b01000);
        chk("t2_cr_c5", s_cr[5], 1'b0);
        chk("t2_cdv_c5", s_cdv[5], 1'b0);
        chk("t2_cdv_c6", s_cdv[6], 1'b0);
        chk("t2_pend_c5", s_pnd[5], 2'd0);

        // Queue fill with grant withheld; order preserved
        clr_log();
        addr_resp = 1;
        addrs[0] = 64'h100;
        addrs[1] = 64'h140;
        addrs[2] = 64'h180;
        addrs[3] = 64'h1C0;
        @(negedge clk);
        bus.lk_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_ac(addrs[i], w);
            chk("t3_no_wait", w, 0);
        end
        bus.ac_valid_i = 1'b1;
        bus.ac_addr_i  = addrs[3];
        #3 chk("t3_full_c3", bus.ac_ready_o, 1'b0);
        repeat (2) @(negedge clk);
        #3 chk("t3_full_c5", bus.ac_ready_o, 1'b0);
        @(negedge clk);
        bus.lk_gnt_i = 1'b1;
        send_ac(addrs[3], w);
        bus.ac_valid_i = 1'b0;
        for (int i = 0; i < 100 && cr_hs < 4; i++) @(negedge clk);
        chk("t3_cr_count", cr_hs, 4);
        if (cr_log.size() == 4) begin
            chk("t3_order0", cr_log[0], 5'b10000);
            chk("t3_order1", cr_log[1], 5'b10100);
            chk("t3_order2", cr_log[2], 5'b11000);
            chk("t3_order3", cr_log[3], 5'b11100);
        end
        addr_resp = 0;

        // CR stall, then CD toggling
        repeat (2) @(negedge clk);
        clr_log();
        cur_resp = 5'b10101;
        cur_line = 128'h0123456789ABCDEF_FEDCBA9876543210;
        bus.cr_ready_i = 1'b0;
        bus.cd_ready_i = 1'b0;
        send_ac(64'h200, w);
        bus.ac_valid_i = 1'b0;
        for (int i = 0; i < 30 && !bus.cr_valid_o; i++) begin
            @(negedge clk);
            #3;
        end
        chk("t4_cr_seen", bus.cr_valid_o, 1'b1);
        repeat (2) @(negedge clk);
        #3 chk("t4_cr_held", bus.cr_valid_o, 1'b1);
        @(negedge clk);
        bus.cr_ready_i = 1'b1;
        bus.cd_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.cd_ready_i = ~bus.cd_ready_i;
        end
        chk("t4_cr_hs", cr_hs, 1);
        chk("t4_cd_hs", cd_hs, 2);
        chk("t4_last_once", cd_lasts, 1);
        if (cd_log.size() == 2) begin
            chk("t4_beat0", cd_log[0], 64'hFEDCBA9876543210);
            chk("t4_beat1", cd_log[1], 64'h0123456789ABCDEF);
        end

        // Reset during DATA beat 0
        @(negedge clk);
        clr_log();
        cur_resp = 5'b00001;
        bus.cd_ready_i = 1'b0;
        send_ac(64'h300, w);
        send_ac(64'h340, w);
        bus.ac_valid_i = 1'b0;
        for (int i = 0; i < 30 && !bus.cd_valid_o; i++) begin
            @(negedge clk);
            #3;
        end
        chk("t5_in_data", bus.cd_valid_o, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("t5_rst_cdv", bus.cd_valid_o, 1'b0);
        chk("t5_rst_data", bus.cd_data_o, '0);
        chk("t5_rst_ready", bus.ac_ready_o, 1'b1);
        chk("t5_rst_pend", pending, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.cd_ready_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #3;
            if (bus.cd_valid_o || bus.lk_req_o) seen++;
        end
        chk("t5_quiet", seen, 0);
        @(negedge clk);
        clr_log();
        send_ac(64'h380, w);
        bus.ac_valid_i = 1'b0;
        for (int i = 0; i < 40 && cd_hs < 2; i++) @(negedge clk);
        chk("t5_after_cd", cd_hs, 2);
        chk("t5_after_cr", cr_hs, 1);
        repeat (2) @(negedge clk);
        #3 chk("t5_after_pend", pending, 2'd0);

        // Push coincident with completion; Error bit forwarded
        @(negedge clk);
        clr_log();
        cur_resp = 5'b01010;
        bus.ac_valid_i = 1'b1;
        bus.ac_addr_i  = 64'h400;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus.ac_valid_i = 1'b0;
        end
        @(negedge clk);
        bus.ac_valid_i = 1'b1;
        bus.ac_addr_i  = 64'h440;
        #3;
        chk("t6_cr_c4", bus.cr_valid_o, 1'b1);
        chk("t6_pend_c4", pending, 2'd1);
        @(negedge clk);
        bus.ac_valid_i = 1'b0;
        #3 chk("t6_pend_c5", pending, 2'd1);
        for (int i = 0; i < 40 && cr_hs < 2; i++) @(negedge clk);
        chk("t6_cr_hs", cr_hs, 2);
        chk("t6_no_cd", cd_hs, 0);
        if (cr_log.size() == 2) begin
            chk("t6_resp0", cr_log[0], 5'b01010);
            chk("t6_resp1", cr_log[1], 5'b01010);
        end
        repeat (2) @(negedge clk);
        #3 chk("t6_pend_end", pending, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
